imem_boot_loader: RTL and testbench

- Upstream feeder for the pipelined MiniMIPS core.
- Receives a framed byte stream from a host link (UART receiver or testbench) over a valid/ready handshake.
- Assembles the bytes into 32-bit instruction words and writes them sequentially into instruction memory through a write port.
- Holds the core in reset until the whole program is loaded, then releases it so fetch starts at PC 0.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/word_assembler.sv | 58 +++++
 rtl/imem_boot_loader.sv | 212 +++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MiniMIPS instruction-memory boot loader.
// Holds the loader state encoding, the default frame sync marker, the
// instruction width and small helper functions used by the loader and its
// word assembler.
package mips_pkg;

    localparam int         INSTR_W       = 32;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } load_state_e;

    // True for every state in which the loader accepts a host byte.
    function automatic logic state_takes_byte(input load_state_e st);
        logic ready;
        case (st)
            SYNC, LEN_HI, LEN_LO, DATA, CSUM: ready = 1'b1;
            WRITE, DONE, ERROR:               ready = 1'b0;
            default:                          ready = 1'b0;
        endcase
        return ready;
    endfunction

    // Running XOR used for the frame checksum.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte-to-word assembler for the boot loader: a 24-bit shift register that,
// together with the incoming byte, forms a big-endian 32-bit word, plus a
// 2-bit byte counter that flags the fourth byte of every word.
// With IMEM_LOADER_CHECKSUM_EN defined it also keeps the XOR of all bytes.
module word_assembler
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word_next,
    output logic               word_full
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]         csum
`endif
);

    logic [INSTR_W-9:0] shift_r;
    logic [1:0]         byte_cnt_r;

    // The word as it stands once the current byte is appended (first byte ends in [31:24]).
    assign word_next = {shift_r, byte_in};
    assign word_full = shift_en & (byte_cnt_r == 2'd3);

    // Shift accepted bytes in and count them; the counter wraps 3->0 on the fourth byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= {(INSTR_W-8){1'b0}};
            byte_cnt_r <= 2'd0;
        end else if (shift_en) begin
            shift_r    <= word_next[INSTR_W-9:0];
            byte_cnt_r <= byte_cnt_r + 2'd1;
        end else begin
            shift_r    <= shift_r;
            byte_cnt_r <= byte_cnt_r;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_r;

    // Accumulate the XOR of every data byte of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_r <= 8'h00;
        end else if (shift_en) begin
            csum_r <= xor_fold(csum_r, byte_in);
        end else begin
            csum_r <= csum_r;
        end
    end

    assign csum = csum_r;
`endif

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader for the MiniMIPS core. Receives a framed byte stream
// (SYNC, LEN_HI, LEN_LO, 4*LEN big-endian data bytes), writes the assembled
// words to instruction memory from address 0 upwards, and holds the core in
// reset until the whole program is in place.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte after the data; a mismatch ends in the error state.
// All outputs are registered and derived from the next state.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         MAX_WORDS = 256,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [ADDR_W:0]    words_loaded
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam load_state_e END_STATE = CSUM;
`else
    localparam load_state_e END_STATE = DONE;
`endif

    load_state_e        state_r;
    load_state_e        state_s;
    logic [15:0]        len_r;
    logic [15:0]        len_full_s;
    logic               accept_s;
    logic               shift_en_s;
    logic               word_full_s;
    logic [INSTR_W-1:0] word_next_s;
    logic [ADDR_W:0]    count_inc_s;

    logic               byte_ready_r;
    logic               imem_we_r;
    logic [ADDR_W-1:0]  imem_addr_r;
    logic [INSTR_W-1:0] imem_wdata_r;
    logic               core_hold_r;
    logic               load_done_r;
    logic               load_err_r;
    logic [ADDR_W:0]    words_loaded_r;

    assign accept_s    = byte_valid & byte_ready_r;
    assign shift_en_s  = accept_s & (state_r == DATA);
    assign len_full_s  = {len_r[15:8], byte_data};
    assign count_inc_s = words_loaded_r + {{ADDR_W{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_s;

    word_assembler u_asm (
        .clk       (CLK),
        .rst_n     (RST),
        .shift_en  (shift_en_s),
        .byte_in   (byte_data),
        .word_next (word_next_s),
        .word_full (word_full_s),
        .csum      (csum_s)
    );
`else
    word_assembler u_asm (
        .clk       (CLK),
        .rst_n     (RST),
        .shift_en  (shift_en_s),
        .byte_in   (byte_data),
        .word_next (word_next_s),
        .word_full (word_full_s)
    );
`endif

    // Next-state logic of the frame parser.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SYNC: begin
                if (accept_s && (byte_data == SYNC_BYTE)) begin
                    state_s = LEN_HI;
                end else begin
                    state_s = SYNC;
                end
            end
            LEN_HI: begin
                if (accept_s) begin
                    state_s = LEN_LO;
                end else begin
                    state_s = LEN_HI;
                end
            end
            LEN_LO: begin
                if (!accept_s) begin
                    state_s = LEN_LO;
                end else if (len_full_s == 16'd0) begin
                    state_s = END_STATE;
                end else if (len_full_s > MAX_LEN) begin
                    state_s = ERROR;
                end else begin
                    state_s = DATA;
                end
            end
            DATA: begin
                if (word_full_s) begin
                    state_s = WRITE;
                end else begin
                    state_s = DATA;
                end
            end
            WRITE: begin
                if (16'(count_inc_s) == len_r) begin
                    state_s = END_STATE;
                end else begin
                    state_s = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (!accept_s) begin
                    state_s = CSUM;
                end else if (byte_data == csum_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ERROR;
                end
            end
`else
            CSUM:    state_s = ERROR;
`endif
            DONE:    state_s = DONE;
            ERROR:   state_s = ERROR;
            default: state_s = ERROR;
        endcase
    end

    // State register and outputs registered from the upcoming state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= SYNC;
            byte_ready_r <= 1'b0;
            imem_we_r    <= 1'b0;
            core_hold_r  <= 1'b1;
            load_done_r  <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            byte_ready_r <= state_takes_byte(state_s);
            imem_we_r    <= (state_s == WRITE);
            core_hold_r  <= (state_s != DONE);
            load_done_r  <= (state_s == DONE);
            load_err_r   <= (state_s == ERROR);
        end
    end

    // Latch the write address/data when a word completes; hold them otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= {INSTR_W{1'b0}};
        end else if (word_full_s) begin
            imem_addr_r  <= words_loaded_r[ADDR_W-1:0];
            imem_wdata_r <= word_next_s;
        end else begin
            imem_addr_r  <= imem_addr_r;
            imem_wdata_r <= imem_wdata_r;
        end
    end

    // Word counter advances as each WRITE cycle completes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            words_loaded_r <= {(ADDR_W+1){1'b0}};
        end else if (state_r == WRITE) begin
            words_loaded_r <= count_inc_s;
        end else begin
            words_loaded_r <= words_loaded_r;
        end
    end

    // Capture the two program-length bytes of the header.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            len_r <= 16'd0;
        end else if (accept_s && (state_r == LEN_HI)) begin
            len_r <= {byte_data, len_r[7:0]};
        end else if (accept_s && (state_r == LEN_LO)) begin
            len_r <= {len_r[15:8], byte_data};
        end else begin
            len_r <= len_r;
        end
    end

    assign byte_ready   = byte_ready_r;
    assign imem_we      = imem_we_r;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = imem_wdata_r;
    assign core_hold    = core_hold_r;
    assign load_done    = load_done_r;
    assign load_err     = load_err_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader. Expected writes go to a scoreboard
// queue as words are sent and are compared when imem_we is seen.
// Honours IMEM_LOADER_CHECKSUM_EN by appending the frame checksum byte.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (256),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int n_writes = 0;
    int n_stalls = 0;
    int w0 = 0;
    bit count_stalls = 1'b0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [7:0]        run_xor = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every write strobe against the oldest expected write.
    always begin
        @(posedge CLK);
        #1;
        if (imem_we === 1'b1) begin
            n_writes++;
            check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
            n_vec++;
            assert (exp_addr_q.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write", imem_addr, imem_wdata);
            end
            if (exp_addr_q.size() > 0) begin
                check("write_addr", {24'd0, imem_addr}, {24'd0, exp_addr_q.pop_front()});
                check("write_data", imem_wdata, exp_data_q.pop_front());
            end
        end
        if (count_stalls && (byte_ready !== 1'b1)) begin
            n_stalls++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while ((byte_ready !== 1'b1) && (n < 40)) begin
            @(negedge CLK);
            n++;
        end
        n_vec++;
        assert (n < 40) else begin
            n_err++;
            $error("FAIL send_timeout: observed ready stuck low for byte %h expected acceptance", b);
        end
        @(negedge CLK);
    endtask

    task automatic start_frame(input logic [15:0] len);
        run_xor = 8'h00;
        send_byte(8'hA5);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(w);
        for (int i = 3; i >= 0; i--) begin
            run_xor = run_xor ^ w[i*8 +: 8];
            send_byte(w[i*8 +: 8]);
        end
    endtask

    task automatic finish_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(run_xor);
`endif
        byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(load_done === 1'b1 || load_err === 1'b1) && (n < 50)) begin
            @(negedge CLK);
            n++;
        end
        n_vec++;
        assert (n < 50) else begin
            n_err++;
            $error("FAIL done_timeout: observed no done/err expected one within 50 cycles");
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        byte_valid = 1'b0;
        RST = 1'b0;
        #2;
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_core_hold", {31'd0, core_hold}, 32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        check("rst_words_loaded", {23'd0, words_loaded}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("ready_after_reset", {31'd0, byte_ready}, 32'd1);
    endtask

    task automatic check_queue_empty(input string tag);
        check(tag, 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        // Two-word program and release timing.
        apply_reset();
        w0 = n_writes;
        start_frame(16'd2);
        send_word(32'h20080005, 8'd0);
        send_word(32'h20090007, 8'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("last_we_high", {31'd0, imem_we}, 32'd1);
        check("hold_during_last_write", {31'd0, core_hold}, 32'd1);
        byte_valid = 1'b0;
        @(negedge CLK);
        check("hold_drops_after_write", {31'd0, core_hold}, 32'd0);
        check("we_single_cycle", {31'd0, imem_we}, 32'd0);
`endif
        finish_frame();
        wait_done();
        check("t1_load_done", {31'd0, load_done}, 32'd1);
        check("t1_core_hold", {31'd0, core_hold}, 32'd0);
        check("t1_words_loaded", {23'd0, words_loaded}, 32'd2);
        check("t1_ready_done", {31'd0, byte_ready}, 32'd0);
        check("t1_writes", 32'(n_writes - w0), 32'd2);
        check_queue_empty("t1_queue_empty");

        // Garbage before sync, empty program.
        apply_reset();
        w0 = n_writes;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        start_frame(16'd0);
        finish_frame();
        wait_done();
        repeat (3) @(negedge CLK);
        check("t2_load_done", {31'd0, load_done}, 32'd1);
        check("t2_core_hold", {31'd0, core_hold}, 32'd0);
        check("t2_no_writes", 32'(n_writes - w0), 32'd0);
        check("t2_words_loaded", {23'd0, words_loaded}, 32'd0);

        // Oversized length goes to the error state for good.
        apply_reset();
        w0 = n_writes;
        start_frame(16'd257);
        byte_data = 8'h20;
        repeat (8) @(negedge CLK);
        check("t3_load_err", {31'd0, load_err}, 32'd1);
        check("t3_core_hold", {31'd0, core_hold}, 32'd1);
        check("t3_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("t3_load_done", {31'd0, load_done}, 32'd0);
        check("t3_no_writes", 32'(n_writes - w0), 32'd0);
        byte_valid = 1'b0;

        // Four words with byte_valid held high throughout.
        apply_reset();
        w0 = n_writes;
        n_stalls = 0;
        count_stalls = 1'b1;
        start_frame(16'd4);
        send_word(32'h01234567, 8'd0);
        send_word(32'h89ABCDEF, 8'd1);
        send_word(32'hA5A5A5A5, 8'd2);
        send_word(32'h00000001, 8'd3);
        count_stalls = 1'b0;
        finish_frame();
        wait_done();
        check("t4_stall_cycles", 32'(n_stalls), 32'd4);
        check("t4_writes", 32'(n_writes - w0), 32'd4);
        check("t4_words_loaded", {23'd0, words_loaded}, 32'd4);
        check("t4_load_done", {31'd0, load_done}, 32'd1);
        check_queue_empty("t4_queue_empty");

        // Reset in the middle of a load, then a clean one-word load.
        apply_reset();
        start_frame(16'd2);
        send_word(32'h11223344, 8'd0);
        send_byte(8'h55);
        apply_reset();
        w0 = n_writes;
        start_frame(16'd1);
        send_word(32'hDEADBEEF, 8'd0);
        finish_frame();
        wait_done();
        check("t5_load_done", {31'd0, load_done}, 32'd1);
        check("t5_words_loaded", {23'd0, words_loaded}, 32'd1);
        check("t5_writes", 32'(n_writes - w0), 32'd1);
        check_queue_empty("t5_queue_empty");

        // Largest legal program: last address is MAX_WORDS-1.
        apply_reset();
        w0 = n_writes;
        start_frame(16'd256);
        for (int i = 0; i < 256; i++) begin
            send_word({8'(i), 8'(255 - i), 8'(i ^ 8'h5A), 8'(i + 3)}, 8'(i));
        end
        finish_frame();
        wait_done();
        check("t6_load_done", {31'd0, load_done}, 32'd1);
        check("t6_load_err", {31'd0, load_err}, 32'd0);
        check("t6_words_loaded", {23'd0, words_loaded}, 32'd256);
        check("t6_last_addr", {24'd0, imem_addr}, 32'd255);
        check("t6_writes", 32'(n_writes - w0), 32'd256);
        check_queue_empty("t6_queue_empty");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch.
        apply_reset();
        start_frame(16'd1);
        send_word(32'h12345678, 8'd0);
        send_byte(8'h08);
        byte_valid = 1'b0;
        wait_done();
        check("t7_csum_ok_done", {31'd0, load_done}, 32'd1);
        check("t7_csum_ok_err", {31'd0, load_err}, 32'd0);

        apply_reset();
        start_frame(16'd1);
        send_word(32'h12345678, 8'd0);
        send_byte(8'h09);
        byte_valid = 1'b0;
        wait_done();
        check("t7_csum_bad_err", {31'd0, load_err}, 32'd1);
        check("t7_csum_bad_hold", {31'd0, core_hold}, 32'd1);
        check("t7_csum_bad_done", {31'd0, load_done}, 32'd0);
        check_queue_empty("t7_queue_empty");
`endif

        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
